// File: rtl/fast_pkg.sv
// Shared constants and the per-point classification encoding for the FAST
// corner pipeline.
package fast_pkg;

   localparam int NUM_PTS     = 16;
   localparam int IDX_W       = $clog2(NUM_PTS);
   localparam int ARC_LEN_MIN = 9;
   localparam int ARC_LEN_MAX = 12;

   typedef enum logic [1:0] {
      CLS_SIMILAR = 2'b00,
      CLS_DARK    = 2'b01,
      CLS_BRIGHT  = 2'b10
   } cls_e;

endpackage

// File: rtl/fast_arc_detect.sv
// Combinational search for a circular run of ARC_LEN equal DARK or BRIGHT
// codes on the 16-point Bresenham circle.
module fast_arc_detect
   import fast_pkg::*;
#(
   parameter int ARC_LEN = 9
) (
   input  logic [NUM_PTS-1:0][1:0] cls,
   output logic                    dark_arc,
   output logic                    bright_arc
);

   // Every start point is tried; the index wraps naturally at IDX_W bits.
   always_comb begin
      logic dark_run;
      logic bright_run;
      logic [IDX_W-1:0] idx;
      dark_arc   = 1'b0;
      bright_arc = 1'b0;
      dark_run   = 1'b0;
      bright_run = 1'b0;
      idx        = '0;
      for (int s = 0; s < NUM_PTS; s++) begin
         dark_run   = 1'b1;
         bright_run = 1'b1;
         for (int k = 0; k < ARC_LEN; k++) begin
            idx        = IDX_W'(s + k);
            dark_run   = dark_run   & (cls[idx] == CLS_DARK);
            bright_run = bright_run & (cls[idx] == CLS_BRIGHT);
         end
         dark_arc   = dark_arc   | dark_run;
         bright_arc = bright_arc | bright_run;
      end
   end

endmodule

// File: rtl/fast_n_corner_pipe.sv
// Three-stage FAST-N corner test: classify, detect arc, sum score. A single
// global stall holds every stage while the consumer back-pressures.
module fast_n_corner_pipe
   import fast_pkg::*;
#(
   parameter int PIX_W   = 8,
   parameter int ARC_LEN = 9,
   parameter int CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PIX_W-1:0]         ref_pix,
   input  logic [NUM_PTS*PIX_W-1:0] adj_pix,
   input  logic [PIX_W-1:0]         thres,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     is_corner,
   output logic [1:0]               corner_pol,
   output logic [PIX_W+3:0]         score,
   input  logic                     cnt_clr,
   output logic [CNT_W-1:0]         corner_cnt
);

   localparam int SCORE_W = PIX_W + 4;

   if (ARC_LEN < ARC_LEN_MIN || ARC_LEN > ARC_LEN_MAX) begin : g_arc_len_err
      $error("fast_n_corner_pipe: ARC_LEN must lie in 9..12");
   end

   logic                           advance;
   logic [PIX_W:0]                 lo_ext_s;
   logic [PIX_W:0]                 up_ext_s;
   logic [PIX_W-1:0]               lower_s;
   logic [PIX_W-1:0]               upper_s;
   logic [NUM_PTS-1:0][1:0]        s1_cls_d;
   logic [NUM_PTS-1:0][1:0]        s1_cls_q;
   logic [NUM_PTS-1:0][PIX_W-1:0]  s1_mrg_d;
   logic [NUM_PTS-1:0][PIX_W-1:0]  s1_mrg_q;
   logic [NUM_PTS-1:0][PIX_W-1:0]  s2_mrg_d;
   logic [NUM_PTS-1:0][PIX_W-1:0]  s2_mrg_q;
   logic                           s1_v_q;
   logic                           s2_v_q;
   logic                           out_valid_q;
   logic                           is_corner_q;
   logic [1:0]                     s2_pol_d;
   logic [1:0]                     s2_pol_q;
   logic [1:0]                     pol_q;
   logic [SCORE_W-1:0]             score_d;
   logic [SCORE_W-1:0]             score_q;
   logic [CNT_W-1:0]               cnt_d;
   logic [CNT_W-1:0]               cnt_q;
   logic                           dark_arc_s;
   logic                           bright_arc_s;

   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   assign lo_ext_s = {1'b0, ref_pix} - {1'b0, thres};
   assign up_ext_s = {1'b0, ref_pix} + {1'b0, thres};
   assign lower_s  = lo_ext_s[PIX_W] ? '0 : lo_ext_s[PIX_W-1:0];
   assign upper_s  = up_ext_s[PIX_W] ? '1 : up_ext_s[PIX_W-1:0];

   // The margin past the bound equals |p - ref| - thres for a classified
   // point, so S3 only has to add the surviving margins.
   for (genvar g = 0; g < NUM_PTS; g++) begin : g_pt
      logic [PIX_W-1:0] pt_s;
      assign pt_s        = adj_pix[PIX_W*(NUM_PTS-g)-1 -: PIX_W];
      assign s1_cls_d[g] = (pt_s < lower_s) ? CLS_DARK :
                           (pt_s > upper_s) ? CLS_BRIGHT : CLS_SIMILAR;
      assign s1_mrg_d[g] = (pt_s < lower_s) ? lower_s - pt_s :
                           (pt_s > upper_s) ? pt_s - upper_s : '0;
      assign s2_mrg_d[g] = (s1_cls_q[g] == s2_pol_d) ? s1_mrg_q[g] : '0;
   end

   fast_arc_detect #(
      .ARC_LEN (ARC_LEN)
   ) u_arc (
      .cls        (s1_cls_q),
      .dark_arc   (dark_arc_s),
      .bright_arc (bright_arc_s)
   );

   assign s2_pol_d = dark_arc_s   ? CLS_DARK   :
                     bright_arc_s ? CLS_BRIGHT : CLS_SIMILAR;

   // Score adder; margins of non-winning points were zeroed in S2.
   always_comb begin
      score_d = '0;
      for (int i = 0; i < NUM_PTS; i++) begin
         score_d = score_d + SCORE_W'(s2_mrg_q[IDX_W'(i)]);
      end
   end

   // Clear has priority over a same-cycle corner transfer.
   always_comb begin
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (out_valid_q && out_ready && is_corner_q && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Pipeline registers, all gated by the global advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q      <= 1'b0;
         s1_cls_q    <= '0;
         s1_mrg_q    <= '0;
         s2_v_q      <= 1'b0;
         s2_pol_q    <= '0;
         s2_mrg_q    <= '0;
         out_valid_q <= 1'b0;
         is_corner_q <= 1'b0;
         pol_q       <= '0;
         score_q     <= '0;
      end else if (advance) begin
         s1_v_q      <= in_valid;
         s1_cls_q    <= s1_cls_d;
         s1_mrg_q    <= s1_mrg_d;
         s2_v_q      <= s1_v_q;
         s2_pol_q    <= s2_pol_d;
         s2_mrg_q    <= s2_mrg_d;
         out_valid_q <= s2_v_q;
         is_corner_q <= (s2_pol_q != CLS_SIMILAR);
         pol_q       <= s2_pol_q;
         score_q     <= score_d;
      end
   end

   // Delivered-corner counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign is_corner  = is_corner_q;
   assign corner_pol = pol_q;
   assign score      = score_q;
   assign corner_cnt = cnt_q;

endmodule

// File: doc/fast_n_corner_pipe.md
FAST_N_CORNER_PIPE -- requirements
Module: fast_n_corner_pipe

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning pixel bit width.
REQ-002 SHALL have parameter ARC_LEN, default 9, meaning required contiguous arc length; legal range 9..12, elaboration error otherwise.
REQ-003 SHALL have parameter CNT_W, default 16, meaning corner counter width.
REQ-004 SHALL provide ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  candidate pixel set present.
- in_ready  output  1  block accepts candidate this cycle.
- ref_pix  input  PIX_W  centre pixel.
- adj_pix  input  16*PIX_W  circle points; point 0 in MSBs, point i at bits [PIX_W*(16-i)-1 -: PIX_W], clockwise order.
- thres  input  PIX_W  threshold, sampled with the candidate.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- is_corner  output  1  arc found.
- corner_pol  output  2  01 dark, 10 bright, 00 none.
- score  output  PIX_W+4  corner strength.
- cnt_clr  input  1  synchronous clear of corner_cnt.
- corner_cnt  output  CNT_W  corners delivered since reset/clear.

Function
REQ-005 SHALL compute lower = ref_pix - thres saturated at 0 and upper = ref_pix + thres saturated at 2^PIX_W-1, using PIX_W+1-bit intermediates.
REQ-006 SHALL classify each point as DARK if p < lower, BRIGHT if p > upper, else SIMILAR (strict compares).
REQ-007 SHALL assert corner when ARC_LEN or more circularly contiguous points share DARK or BRIGHT, including arcs wrapping from point 15 to point 0.
REQ-008 SHALL set corner_pol to the winning class; DARK and BRIGHT cannot both qualify because ARC_LEN >= 9.
REQ-009 SHALL compute score = sum over points of the winning class of (|p - ref_pix| - thres), unsigned, no overflow; score = 0 and corner_pol = 00 when is_corner = 0.
REQ-010 SHALL be a 3-stage pipeline: S1 bounds, classification and per-point differences; S2 arc detection; S3 score sum and output register. Latency is 3 cycles from accept to out_valid with no stall.
REQ-011 SHALL accept a candidate when in_valid && in_ready; SHALL transfer a result when out_valid && out_ready.
REQ-012 SHALL define advance = !out_valid || out_ready; in_ready = advance; all stages hold when advance = 0 (global stall, no bubble compression required).
REQ-013 SHALL keep out_valid and all result outputs stable while out_valid && !out_ready.
REQ-014 SHALL sustain one candidate per cycle when out_ready is held high.
REQ-015 SHALL increment corner_cnt by 1 on each transfer with is_corner = 1, saturating at 2^CNT_W-1.
REQ-016 SHALL give cnt_clr priority over a same-cycle increment (result 0).
REQ-017 SHALL treat thres = 0 as legal: any p != ref_pix is classified.

Reset
REQ-018 SHALL, on rst asserted, asynchronously clear all stage valid flags, out_valid, is_corner, corner_pol, score and corner_cnt to 0.
REQ-019 SHALL discard in-flight candidates on reset mid-operation; no result appears for them after release.
REQ-020 SHALL drive in_ready = 1 in the first cycle after reset release.

Structure
REQ-021 SHALL place NUM_PTS = 16, the classification encoding (SIMILAR 00, DARK 01, BRIGHT 10) and the arc-length range limits in shared package fast_pkg.
REQ-022 SHALL implement arc detection in a combinational sub-module fast_arc_detect (inputs: 16 class codes, parameter ARC_LEN; outputs: dark_arc, bright_arc), instanced once in S2.

Verification
REQ-023 SHALL pass: ref 100, thres 20, points 0-8 = 130, rest 100, ARC_LEN 9 -> after 3 cycles is_corner 1, pol 10, score 90, corner_cnt 1.
REQ-024 SHALL pass: ref 100, thres 20, points 12-15 and 0-4 = 50, rest 100 (wrapping arc) -> is_corner 1, pol 01, score 270; with ARC_LEN 10 the same input -> is_corner 0, score 0.
REQ-025 SHALL pass: ref 250, thres 20, all points 255 -> upper saturates to 255, no BRIGHT, is_corner 0; ref 5, thres 20, all points 0 -> lower 0, is_corner 0.
REQ-026 SHALL pass: 8 back-to-back corner candidates, out_ready low for cycles 4-6 -> in_ready low while stalled, outputs stable, all 8 results delivered in order, corner_cnt 8.
REQ-027 SHALL pass: rst pulsed with 2 candidates in flight -> no out_valid afterwards, corner_cnt 0; cnt_clr coincident with a corner transfer -> corner_cnt 0.
